// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Brief    : Requester and write-port bundle for the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    localparam int c_PTR_W = $clog2(NUM_REQ);

    logic                        flush;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic [ADDR_W-1:0]           write_addr0;
    logic                        write_addr0_valid;
    logic [DATA_W-1:0]           write_data0;
    logic [ADDR_W-1:0]           write_addr1;
    logic                        write_addr1_valid;
    logic [DATA_W-1:0]           write_data1;
    logic [c_PTR_W-1:0]          rr_ptr;

    modport master (
        output flush, req_valid, req_addr, req_data,
        input  req_ready, write_addr0, write_addr0_valid, write_data0,
               write_addr1, write_addr1_valid, write_data1, rr_ptr
    );

    modport slave (
        input  flush, req_valid, req_addr, req_data,
        output req_ready, write_addr0, write_addr0_valid, write_data0,
               write_addr1, write_addr1_valid, write_data1, rr_ptr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Round-robin arbiter granting two result sources per cycle onto
//            the register file's two registered write ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int c_PTR_W = $clog2(NUM_REQ);

    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [ADDR_W-1:0]  r_addr0, r_addr1;
    logic [DATA_W-1:0]  r_data0, r_data1;
    logic               r_valid0, r_valid1;

    logic [c_PTR_W:0]   w_sum;
    logic [c_PTR_W-1:0] w_scan;
    logic [ADDR_W-1:0]  w_cand_addr;
    logic               w_a_found, w_b_found;
    logic [c_PTR_W-1:0] w_a_idx, w_b_idx;
    logic [ADDR_W-1:0]  w_a_addr, w_b_addr;
    logic [DATA_W-1:0]  w_a_data, w_b_data;
    logic               w_gnt_a, w_gnt_b;
    logic [c_PTR_W-1:0] w_last, w_ptr_nxt;
    logic [NUM_REQ-1:0] w_ready;

    // Walk requesters from the pointer; B must not collide with A's
    // destination unless A targets the discard register 0.
    always_comb begin
        w_sum       = '0;
        w_scan      = '0;
        w_cand_addr = '0;
        w_a_found   = 1'b0;
        w_b_found   = 1'b0;
        w_a_idx     = '0;
        w_b_idx     = '0;
        w_a_addr    = '0;
        w_b_addr    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(k);
            if (w_sum >= (c_PTR_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_PTR_W+1)'(NUM_REQ);
            end
            w_scan      = w_sum[c_PTR_W-1:0];
            w_cand_addr = bus.req_addr[int'(w_scan)*ADDR_W +: ADDR_W];
            if (bus.req_valid[w_scan]) begin
                if (!w_a_found) begin
                    w_a_found = 1'b1;
                    w_a_idx   = w_scan;
                    w_a_addr  = w_cand_addr;
                end else if (!w_b_found &&
                             ((w_cand_addr != w_a_addr) || (w_a_addr == '0))) begin
                    w_b_found = 1'b1;
                    w_b_idx   = w_scan;
                    w_b_addr  = w_cand_addr;
                end
            end
        end
    end

    assign w_a_data = bus.req_data[int'(w_a_idx)*DATA_W +: DATA_W];
    assign w_b_data = bus.req_data[int'(w_b_idx)*DATA_W +: DATA_W];

    // No grants while flushing or held in reset.
    assign w_gnt_a = w_a_found & ~bus.flush & rst_n;
    assign w_gnt_b = w_b_found & w_gnt_a;

    assign w_last    = w_gnt_b ? w_b_idx : w_a_idx;
    assign w_ptr_nxt = (w_last == c_PTR_W'(NUM_REQ-1)) ? '0 : w_last + 1'b1;

    always_comb begin
        w_ready = '0;
        if (w_gnt_a) begin
            w_ready[w_a_idx] = 1'b1;
        end
        if (w_gnt_b) begin
            w_ready[w_b_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_addr0  <= '0;
            r_addr1  <= '0;
            r_data0  <= '0;
            r_data1  <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            // Register 0 grants consume a slot but never write.
            r_valid0 <= w_gnt_a && (w_a_addr != '0);
            r_valid1 <= w_gnt_b && (w_b_addr != '0);
            if (w_gnt_a) begin
                r_addr0  <= w_a_addr;
                r_data0  <= w_a_data;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (w_gnt_b) begin
                r_addr1 <= w_b_addr;
                r_data1 <= w_b_data;
            end
        end
    end

    assign bus.req_ready         = w_ready;
    assign bus.write_addr0       = r_addr0;
    assign bus.write_addr0_valid = r_valid0;
    assign bus.write_data0       = r_data0;
    assign bus.write_addr1       = r_addr1;
    assign bus.write_addr1_valid = r_valid1;
    assign bus.write_data1       = r_data1;
    assign bus.rr_ptr            = r_rr_ptr;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Scoreboard bench for regfile_wb_arbiter with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    localparam int N = 4;
    localparam int A = 5;
    localparam int D = 32;

    typedef struct {
        int           cyc;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   m_ptr = 0;
    exp_t q0[$];
    exp_t q1[$];

    regfile_wb_arbiter_if #(.NUM_REQ(N), .DATA_W(D), .ADDR_W(A)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(D), .ADDR_W(A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: list valid requesters in rotating order, A is the first,
    // B is the first later one not colliding with A.
    function automatic void model(input logic [N-1:0] v, input logic [A-1:0] ad[N],
                                  input int ptr, output int ga, output int gb);
        int cand[$];
        ga = -1;
        gb = -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) cand.push_back((ptr + k) % N);
        end
        if (cand.size() > 0) begin
            ga = cand[0];
            for (int j = 1; j < cand.size(); j++) begin
                if (gb < 0 && (ad[cand[j]] != ad[ga] || ad[ga] == 0)) gb = cand[j];
            end
        end
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [A-1:0] ad[N],
                        input logic [D-1:0] dd[N], input logic f,
                        output logic [N-1:0] hs);
        int ga, gb;
        logic [N-1:0] exp_ready;
        @(posedge clk);
        #1;
        bus.flush     = f;
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*A +: A] = ad[i];
            bus.req_data[i*D +: D] = dd[i];
        end
        #2;
        chk("rr_ptr", bus.rr_ptr, m_ptr);
        model(v, ad, m_ptr, ga, gb);
        if (f) begin
            ga = -1;
            gb = -1;
        end
        exp_ready = '0;
        if (ga >= 0) exp_ready[ga] = 1'b1;
        if (gb >= 0) exp_ready[gb] = 1'b1;
        chk("req_ready", bus.req_ready, exp_ready);
        if (ga >= 0 && ad[ga] != 0) q0.push_back('{cyc + 1, ad[ga], dd[ga]});
        if (gb >= 0 && ad[gb] != 0) q1.push_back('{cyc + 1, ad[gb], dd[gb]});
        if (ga >= 0) m_ptr = ((gb >= 0 ? gb : ga) + 1) % N;
        hs = exp_ready;
    endtask

    // Monitor: each cycle, a port must be valid exactly when the scoreboard
    // holds an entry due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (q0.size() > 0 && q0[0].cyc == cyc) begin
                    e = q0.pop_front();
                    chk("port0_valid", bus.write_addr0_valid, 1);
                    chk("port0_addr", bus.write_addr0, e.addr);
                    chk("port0_data", bus.write_data0, e.data);
                end else begin
                    chk("port0_idle", bus.write_addr0_valid, 0);
                end
                if (q1.size() > 0 && q1[0].cyc == cyc) begin
                    e = q1.pop_front();
                    chk("port1_valid", bus.write_addr1_valid, 1);
                    chk("port1_addr", bus.write_addr1, e.addr);
                    chk("port1_data", bus.write_data1, e.data);
                end else begin
                    chk("port1_idle", bus.write_addr1_valid, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v;
        logic [N-1:0] hs;
        logic [A-1:0] ad[N];
        logic [D-1:0] dd[N];
        logic         f;

        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.req_valid = '1;
        bus.req_addr  = {A'(1), A'(2), A'(3), A'(4)};
        bus.req_data  = '1;
        #12;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_v0", bus.write_addr0_valid, 0);
        chk("rst_v1", bus.write_addr1_valid, 0);
        chk("rst_ptr", bus.rr_ptr, 0);
        chk("rst_addr0", bus.write_addr0, 0);
        chk("rst_data1", bus.write_data1, 0);
        bus.req_valid = '0;
        #1;
        rst_n = 1'b1;

        dd = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
        ad = '{5'd0, 5'd0, 5'd7, 5'd0};
        step(4'b0100, ad, dd, 1'b0, hs);
        ad = '{5'd0, 5'd0, 5'd0, 5'd1};
        step(4'b1000, ad, dd, 1'b0, hs);
        ad = '{5'd1, 5'd2, 5'd3, 5'd4};
        step(4'b1111, ad, dd, 1'b0, hs);
        step(4'b1111, ad, dd, 1'b0, hs);
        ad = '{5'd9, 5'd9, 5'd0, 5'd0};
        step(4'b0011, ad, dd, 1'b0, hs);
        step(4'b0010, ad, dd, 1'b0, hs);
        ad = '{5'd0, 5'd0, 5'd0, 5'd5};
        step(4'b1010, ad, dd, 1'b0, hs);
        ad = '{5'd6, 5'd2, 5'd3, 5'd4};
        step(4'b0001, ad, dd, 1'b0, hs);
        step(4'b1111, ad, dd, 1'b1, hs);
        step(4'b0000, ad, dd, 1'b0, hs);

        // Random traffic; requesters hold addr/data until accepted.
        v  = '0;
        hs = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(v[i] && !hs[i])) begin
                    v[i]  = ($urandom % 100) < 60;
                    ad[i] = ($urandom % 2) ? A'($urandom % 4) : A'($urandom % 32);
                    dd[i] = $urandom;
                end
            end
            f = ($urandom % 10) == 0;
            step(v, ad, dd, f, hs);
        end

        // Async reset while a write is on the ports.
        ad = '{5'd5, 5'd0, 5'd0, 5'd0};
        step(4'b0001, ad, dd, 1'b0, hs);
        @(posedge clk);
        #3;
        chk("pre_rst_v0", bus.write_addr0_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_v0", bus.write_addr0_valid, 0);
        chk("async_rst_v1", bus.write_addr1_valid, 0);
        chk("async_rst_ptr", bus.rr_ptr, 0);
        chk("async_rst_ready", bus.req_ready, 0);
        @(posedge clk);
        #2;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
